// File: rtl/operand_entry_if.sv
// Front-panel bundle for the operand-entry unit: raw buttons and operand
// select from the panel side, and operand/cursor/display outputs back to it.
interface operand_entry_if #(
  parameter int WIDTH       = 64,
  parameter int NUM_OPS     = 2,
  parameter int PAGE_DIGITS = 4
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int NPG = NIB / PAGE_DIGITS;
  localparam int PW  = (NPG > 1) ? $clog2(NPG) : 1;

  logic                     btn_left;
  logic                     btn_right;
  logic                     btn_inc;
  logic                     btn_dec;
  logic                     btn_clr;
  logic [2:0]               op_sel;
  logic [NUM_OPS*WIDTH-1:0] operands;
  logic [CW-1:0]            cursor;
  logic [PW-1:0]            page;
  logic [PAGE_DIGITS-1:0]   blink_mask;
  logic                     edit_pulse;

  modport master (
    output btn_left, btn_right, btn_inc, btn_dec, btn_clr, op_sel,
    input  operands, cursor, page, blink_mask, edit_pulse
  );

  modport slave (
    input  btn_left, btn_right, btn_inc, btn_dec, btn_clr, op_sel,
    output operands, cursor, page, blink_mask, edit_pulse
  );
endinterface

// File: rtl/operand_entry_ctrl.sv
// Operand-entry controller: NUM_OPS hex operands edited a nibble at a time
// from push buttons, with a shared cursor and a blinking digit mask.
// Optional macro OPERAND_ENTRY_REPEAT_EN adds auto-repeat on held inc/dec.
module operand_entry_ctrl #(
  parameter int WIDTH       = 64,
  parameter int NUM_OPS     = 2,
  parameter int PAGE_DIGITS = 4,
  parameter int BLINK_HALF  = 25000000,
  parameter int REPEAT_DLY  = 50000000,
  parameter int REPEAT_PER  = 10000000
) (
  input  logic            clk,
  input  logic            rst_n,
  operand_entry_if.slave  bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int NPG = NIB / PAGE_DIGITS;
  localparam int PW  = (NPG > 1) ? $clog2(NPG) : 1;
  localparam int BW  = $clog2(BLINK_HALF + 1);
  localparam logic [3:0] NOPS = 4'(NUM_OPS);

  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_INC   = 2;
  localparam int B_DEC   = 3;
  localparam int B_CLR   = 4;

  if ((WIDTH % 4) != 0 || NUM_OPS < 1 || NUM_OPS > 8 || PAGE_DIGITS < 1 ||
      (NIB % PAGE_DIGITS) != 0 || BLINK_HALF < 1 || REPEAT_DLY < 1 ||
      REPEAT_PER < 1) begin : g_bad_param
    $error("operand_entry_ctrl: illegal parameter combination");
  end

  logic [4:0] btn_raw, s1, s2, s3, armed, ev;
  logic       started;

  assign btn_raw = {bus.btn_clr, bus.btn_dec, bus.btn_inc, bus.btn_right, bus.btn_left};

  // Synchronise buttons, keep a previous-value flop for edge detect, and arm
  // each button only once it has been seen low after reset so that a button
  // held through reset release cannot fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      armed   <= '0;
      started <= 1'b0;
    end else begin
      s1      <= btn_raw;
      s2      <= s1;
      s3      <= s2;
      started <= 1'b1;
      armed   <= armed | ({5{started}} & ~s1 & ~s2);
    end
  end

  assign ev = s2 & ~s3 & armed;

  logic rep_inc, rep_dec;

`ifdef OPERAND_ENTRY_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);

  logic          hold_inc, hold_dec, hold, rep_act;
  logic [RW-1:0] rep_cnt;

  assign hold_inc = s2[B_INC] & ~s2[B_DEC] & armed[B_INC];
  assign hold_dec = s2[B_DEC] & ~s2[B_INC] & armed[B_DEC];
  assign hold     = hold_inc | hold_dec;

  // Hold timer: loads the initial delay on the first held cycle, then
  // reloads the repeat period at each terminal count until release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_act <= 1'b0;
      rep_cnt <= '0;
    end else if (!hold) begin
      rep_act <= 1'b0;
      rep_cnt <= '0;
    end else if (!rep_act) begin
      rep_act <= 1'b1;
      rep_cnt <= RW'(REPEAT_DLY - 1);
    end else if (rep_cnt == '0) begin
      rep_cnt <= RW'(REPEAT_PER - 1);
    end else begin
      rep_cnt <= rep_cnt - 1'b1;
    end
  end

  assign rep_inc = hold_inc & rep_act & (rep_cnt == '0);
  assign rep_dec = hold_dec & rep_act & (rep_cnt == '0);
`else
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

  logic sel_ok, inc_any, dec_any;
  logic do_clr, do_inc, do_dec, do_left, do_right;

  assign sel_ok  = {1'b0, bus.op_sel} < NOPS;
  assign inc_any = ev[B_INC] | rep_inc;
  assign dec_any = ev[B_DEC] | rep_dec;

  // Resolve one action per cycle: clear beats nibble edit beats cursor move;
  // ignored events (conflicting pairs, invalid select) do not block lower ones.
  always_comb begin
    do_clr   = 1'b0;
    do_inc   = 1'b0;
    do_dec   = 1'b0;
    do_left  = 1'b0;
    do_right = 1'b0;
    if (ev[B_CLR] && sel_ok) begin
      do_clr = 1'b1;
    end else if ((inc_any ^ dec_any) && sel_ok) begin
      do_inc = inc_any;
      do_dec = dec_any;
    end else if (ev[B_LEFT] ^ ev[B_RIGHT]) begin
      do_left  = ev[B_LEFT];
      do_right = ev[B_RIGHT];
    end
  end

  logic [CW-1:0]    cursor, cursor_nxt;
  logic [CW+1:0]    nib_lsb;
  logic [WIDTH-1:0] ops [NUM_OPS];
  logic             edit_q;

  assign nib_lsb = {cursor, 2'b00};

  // Operand registers: nibble arithmetic wraps inside the nibble, no carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OPS; k++) ops[k] <= '0;
      edit_q <= 1'b0;
    end else begin
      edit_q <= do_clr | do_inc | do_dec;
      for (int k = 0; k < NUM_OPS; k++) begin
        if (bus.op_sel == 3'(k)) begin
          if (do_clr)
            ops[k] <= '0;
          else if (do_inc)
            ops[k][nib_lsb +: 4] <= ops[k][nib_lsb +: 4] + 4'd1;
          else if (do_dec)
            ops[k][nib_lsb +: 4] <= ops[k][nib_lsb +: 4] - 4'd1;
        end
      end
    end
  end

  // Next cursor with wrap at both ends.
  always_comb begin
    cursor_nxt = cursor;
    if (do_left)
      cursor_nxt = (cursor == CW'(NIB - 1)) ? '0 : cursor + 1'b1;
    else if (do_right)
      cursor_nxt = (cursor == '0) ? CW'(NIB - 1) : cursor - 1'b1;
  end

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Cursor and blink timer; a move restarts the blink in the visible phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor      <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (do_left || do_right) begin
      cursor      <= cursor_nxt;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_ops_out
    assign bus.operands[k*WIDTH +: WIDTH] = ops[k];
  end

  assign bus.cursor     = cursor;
  assign bus.page       = PW'(32'(cursor) / PAGE_DIGITS);
  assign bus.blink_mask = (blink_phase && sel_ok)
                        ? (PAGE_DIGITS'(1) << (32'(cursor) % PAGE_DIGITS))
                        : '0;
  assign bus.edit_pulse = edit_q;
endmodule
